// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-ported register file: control polarities,
// the zero-word bit and the clear-sweep FSM state encoding.
package reg_file_mp_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic RstDisable  = 1'b0;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;
    // Replicated to DATA_W wherever an all-zero word is needed.
    localparam logic ZeroWord    = 1'b0;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/reg_file_wr_arb.sv
// Resolves the enabled write ports that target one query address: highest
// port index wins; multi flags two or more enabled ports hitting it.
module reg_file_wr_arb
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]        qaddr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data,
    output logic                     multi
);

    logic              hit_s;
    logic              multi_s;
    logic              match_s;
    logic [DATA_W-1:0] data_s;

    // Scan ports low to high so a later (higher-priority) match overrides.
    always_comb begin
        hit_s   = 1'b0;
        multi_s = 1'b0;
        match_s = 1'b0;
        data_s  = {DATA_W{ZeroWord}};
        for (int i = 0; i < NUM_WR; i++) begin
            match_s = (we[i] == WriteEnable) && (waddr[i*ADDR_W +: ADDR_W] == qaddr);
            multi_s = multi_s | (hit_s & match_s);
            hit_s   = hit_s | match_s;
            data_s  = match_s ? wdata[i*DATA_W +: DATA_W] : data_s;
        end
    end

    assign hit   = hit_s;
    assign data  = data_s;
    assign multi = multi_s;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with prioritised writes, write-first read bypass,
// optional hardwired-zero r0 and a post-reset clear sweep.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     init_done,
    output logic                     wr_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    state_e              state_r;
    state_e              state_nx_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [DATA_W-1:0]   regs_r [DEPTH];
    logic                wr_conflict_r;
    logic                ready_s;
    logic [DEPTH-1:0]    wr_en_s;
    logic [DEPTH-1:0]    wr_multi_s;
    logic [DATA_W-1:0]   wr_data_s [DEPTH];
    logic                conflict_s;

    assign ready_s = (state_r == ST_READY) && (rst == RstDisable);

    // One resolver per storage slot; r0 is masked out entirely when hardwired.
    for (genvar a = 0; a < DEPTH; a++) begin : g_wr
        localparam bit KEEP = !(ZERO_R0 && (a == 0));
        logic hit_s;
        logic multi_s;

        reg_file_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_arb (
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .qaddr (ADDR_W'(a)),
            .hit   (hit_s),
            .data  (wr_data_s[a]),
            .multi (multi_s)
        );

        assign wr_en_s[a]    = hit_s & KEEP;
        assign wr_multi_s[a] = multi_s & KEEP;
    end

    assign conflict_s = |wr_multi_s;

    // Sweep-state register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Leave INIT once the last index has been cleared.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (idx_r == {ADDR_W{1'b1}}) begin
                    state_nx_s = ST_READY;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_READY: state_nx_s = ST_READY;
            default:  state_nx_s = ST_INIT;
        endcase
    end

    // Storage: clear sweep in INIT, resolved port writes in READY.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            idx_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            regs_r[idx_r] <= {DATA_W{ZeroWord}};
            idx_r         <= idx_r + ADDR_W'(1);
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr_en_s[a]) begin
                    regs_r[a] <= wr_data_s[a];
                end
            end
        end
    end

    // Conflict flag reports the previous cycle's READY-state writes.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_conflict_r <= 1'b0;
        end else if (state_r == ST_READY) begin
            wr_conflict_r <= conflict_s;
        end else begin
            wr_conflict_r <= 1'b0;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic              hit_s;
        logic              rd_multi_unused_s;
        logic [DATA_W-1:0] byp_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = raddr[j*ADDR_W +: ADDR_W];

        reg_file_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_byp (
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .qaddr (ra_s),
            .hit   (hit_s),
            .data  (byp_s),
            .multi (rd_multi_unused_s)
        );

        // Read priority: not ready, disabled, hardwired zero, bypass, storage.
        always_comb begin
            rd_s = {DATA_W{ZeroWord}};
            if (!ready_s) begin
                rd_s = {DATA_W{ZeroWord}};
            end else if (re[j] != ReadEnable) begin
                rd_s = {DATA_W{ZeroWord}};
            end else if (ZERO_R0 && (ra_s == {ADDR_W{1'b0}})) begin
                rd_s = {DATA_W{ZeroWord}};
            end else if (hit_s) begin
                rd_s = byp_s;
            end else begin
                rd_s = regs_r[ra_s];
            end
        end

        assign rdata[j*DATA_W +: DATA_W] = rd_s;
    end

    assign init_done   = ready_s;
    assign wr_conflict = (rst == RstDisable) ? wr_conflict_r : 1'b0;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three instances (4R/2W zero-r0, 4R/2W plain r0,
// 1R/1W zero-r0) checked every cycle against an array-based model.
module tb_reg_file_mp;

    localparam int DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   we    [3];
    logic [9:0]   waddr [3];
    logic [63:0]  wdata [3];
    logic [3:0]   re    [3];
    logic [19:0]  raddr [3];
    logic [127:0] rdata0;
    logic [127:0] rdata1;
    logic [31:0]  rdata2;
    logic         init_done   [3];
    logic         wr_conflict [3];

    int n_chk;
    int n_pass;
    bit chk_en = 1'b0;

    logic [31:0] mem  [3][DEPTH];
    int          cnt  [3];
    bit          conf [3];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .ZERO_R0(1'b1)) dut0 (
        .clk(clk), .rst(rst), .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]),
        .re(re[0]), .raddr(raddr[0]), .rdata(rdata0),
        .init_done(init_done[0]), .wr_conflict(wr_conflict[0])
    );

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .ZERO_R0(1'b0)) dut1 (
        .clk(clk), .rst(rst), .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]),
        .re(re[1]), .raddr(raddr[1]), .rdata(rdata1),
        .init_done(init_done[1]), .wr_conflict(wr_conflict[1])
    );

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .NUM_WR(1), .ZERO_R0(1'b1)) dut2 (
        .clk(clk), .rst(rst), .we(we[2][0:0]), .waddr(waddr[2][4:0]), .wdata(wdata[2][31:0]),
        .re(re[2][0:0]), .raddr(raddr[2][4:0]), .rdata(rdata2),
        .init_done(init_done[2]), .wr_conflict(wr_conflict[2])
    );

    function automatic int nw(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic int nr(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit zr(input int k);
        return (k != 1);
    endfunction

    function automatic logic [31:0] dut_rd(input int k, input int j);
        case (k)
            0:       return rdata0[j*32 +: 32];
            1:       return rdata1[j*32 +: 32];
            default: return rdata2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Expected read value from the register-file rules.
    function automatic logic [31:0] exp_rd(input int k, input int j);
        logic [4:0]  ra;
        logic [31:0] v;
        ra = raddr[k][j*5 +: 5];
        if (rst || cnt[k] < DEPTH) return 32'd0;
        if (!re[k][j]) return 32'd0;
        if (zr(k) && ra == 5'd0) return 32'd0;
        v = mem[k][ra];
        for (int p = 0; p < nw(k); p++) begin
            if (we[k][p] && waddr[k][p*5 +: 5] == ra) v = wdata[k][p*32 +: 32];
        end
        return v;
    endfunction

    // Compare all outputs, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("dut%0d_init_done", k), {31'd0, init_done[k]},
                    (!rst && cnt[k] >= DEPTH) ? 32'd1 : 32'd0);
                chk($sformatf("dut%0d_wr_conflict", k), {31'd0, wr_conflict[k]},
                    (!rst && conf[k]) ? 32'd1 : 32'd0);
                for (int j = 0; j < nr(k); j++) begin
                    chk($sformatf("dut%0d_rdata%0d", k, j), dut_rd(k, j), exp_rd(k, j));
                end
                if (rst) begin
                    cnt[k]  = 0;
                    conf[k] = 1'b0;
                    for (int a = 0; a < DEPTH; a++) mem[k][a] = 32'd0;
                end else if (cnt[k] < DEPTH) begin
                    cnt[k]  = cnt[k] + 1;
                    conf[k] = 1'b0;
                end else begin
                    conf[k] = 1'b0;
                    for (int a = 0; a < DEPTH; a++) begin
                        int          n;
                        logic [31:0] v;
                        n = 0;
                        v = 32'd0;
                        for (int p = 0; p < nw(k); p++) begin
                            if (we[k][p] && waddr[k][p*5 +: 5] == a[4:0]) begin
                                n++;
                                v = wdata[k][p*32 +: 32];
                            end
                        end
                        if (!(zr(k) && a == 0)) begin
                            if (n > 0) mem[k][a] = v;
                            if (n > 1) conf[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            we[k] = 2'b0; waddr[k] = 10'd0; wdata[k] = 64'd0;
            re[k] = 4'b0; raddr[k] = 20'd0;
        end
    endtask

    task automatic set_wr(input int p, input bit en, input logic [4:0] a, input logic [31:0] d);
        for (int k = 0; k < 3; k++) begin
            if (p < nw(k)) begin
                we[k][p] = en; waddr[k][p*5 +: 5] = a; wdata[k][p*32 +: 32] = d;
            end
        end
    endtask

    task automatic clear_wr();
        for (int k = 0; k < 3; k++) we[k] = 2'b0;
    endtask

    task automatic set_rd(input int j, input bit en, input logic [4:0] a);
        for (int k = 0; k < 3; k++) begin
            if (j < nr(k)) begin
                re[k][j] = en; raddr[k][j*5 +: 5] = a;
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        clear_inputs();
        chk_en = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Sweep timing; a write in cycle 10 must be dropped.
        for (int c = 1; c <= 32; c++) begin
            step();
            if (c == 9) set_wr(0, 1'b1, 5'd5, 32'h0000_DEAD);
            else clear_wr();
            look();
            if (c == 31) chk("init_done_c31", {31'd0, init_done[0]}, 32'd0);
            if (c == 32) chk("init_done_c32", {31'd0, init_done[0]}, 32'd1);
        end
        set_rd(0, 1'b1, 5'd5);
        look();
        chk("r5_dropped", dut_rd(0, 0), 32'd0);

        // Basic write then read on all ports, port 2 disabled.
        step();
        set_wr(0, 1'b1, 5'd7, 32'h1234_5678);
        step();
        clear_wr();
        for (int j = 0; j < 4; j++) set_rd(j, (j != 2), 5'd7);
        look();
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("basic_rd%0d", j), dut_rd(0, j), (j == 2) ? 32'd0 : 32'h1234_5678);
        end
        chk("basic_1r1w", dut_rd(2, 0), 32'h1234_5678);

        // Same-cycle double write: bypass picks port 1, conflict next cycle.
        step();
        set_wr(0, 1'b1, 5'd9, 32'h0000_AAAA);
        set_wr(1, 1'b1, 5'd9, 32'h0000_BBBB);
        set_rd(0, 1'b1, 5'd9);
        look();
        chk("bypass_prio", dut_rd(0, 0), 32'h0000_BBBB);
        chk("bypass_1r1w", dut_rd(2, 0), 32'h0000_AAAA);
        step();
        clear_wr();
        chk("model_r9", mem[0][9], 32'h0000_BBBB);
        look();
        chk("conflict_r9", {31'd0, wr_conflict[0]}, 32'd1);
        chk("r9_stored", dut_rd(0, 0), 32'h0000_BBBB);
        chk("conflict_1w", {31'd0, wr_conflict[2]}, 32'd0);

        // r0 hardwired versus ordinary.
        step();
        set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        set_wr(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        set_rd(0, 1'b1, 5'd0);
        look();
        chk("r0_zero_byp", dut_rd(0, 0), 32'd0);
        chk("r0_plain_byp", dut_rd(1, 0), 32'hFFFF_FFFF);
        step();
        clear_wr();
        chk("model_r0_plain", mem[1][0], 32'hFFFF_FFFF);
        look();
        chk("r0_zero_noconf", {31'd0, wr_conflict[0]}, 32'd0);
        chk("r0_plain_conf", {31'd0, wr_conflict[1]}, 32'd1);
        chk("r0_zero_rd", dut_rd(0, 0), 32'd0);
        chk("r0_plain_rd", dut_rd(1, 0), 32'hFFFF_FFFF);

        // Reset in READY and in mid-sweep at index 17.
        step();
        set_wr(0, 1'b1, 5'd12, 32'h0000_0055);
        step();
        clear_wr();
        set_rd(0, 1'b1, 5'd12);
        look();
        chk("r12_written", dut_rd(0, 0), 32'h0000_0055);
        step();
        rst = 1'b1;
        look();
        chk("init_done_drop", {31'd0, init_done[0]}, 32'd0);
        step();
        rst = 1'b0;
        repeat (17) step();
        rst = 1'b1;
        look();
        chk("init_done_mid", {31'd0, init_done[0]}, 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            step();
            look();
            if (c == 31) chk("resweep_c31", {31'd0, init_done[0]}, 32'd0);
            if (c == 32) chk("resweep_c32", {31'd0, init_done[0]}, 32'd1);
        end
        chk("r12_cleared", dut_rd(0, 0), 32'd0);

        // Randomised traffic, addresses often squeezed to force collisions.
        for (int i = 0; i < 10000; i++) begin
            step();
            rst = ($urandom_range(0, 2999) == 0);
            for (int k = 0; k < 3; k++) begin
                bit narrow;
                narrow   = ($urandom_range(0, 1) == 1);
                we[k]    = 2'($urandom_range(0, 3));
                re[k]    = 4'($urandom_range(0, 15));
                wdata[k] = {$urandom(), $urandom()};
                for (int p = 0; p < 2; p++) begin
                    waddr[k][p*5 +: 5] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                end
                for (int j = 0; j < 4; j++) begin
                    raddr[k][j*5 +: 5] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                end
            end
        end
        look();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
